// File: rtl/credit_switch_allocator_3port.sv
// ============================================================================
// Module      : credit_switch_allocator_3port
// Description : 3x3 switch allocator, one round-robin arbiter per output port.
//               SA_CREDIT_EN selects credit-counter flow control, else full_in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SW_STOP
`define SW_STOP  3'b000
`endif
`ifndef SW_X1
`define SW_X1    3'b001
`endif
`ifndef SW_Y1
`define SW_Y1    3'b010
`endif
`ifndef SW_LOCAL
`define SW_LOCAL 3'b100
`endif

module credit_switch_allocator_3port #(
  parameter int CREDIT_DEPTH = 8,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_req_valid,
  input  logic [1:0] i_req_dst_x,
  input  logic [1:0] i_req_dst_y,
  input  logic [1:0] i_req_dst_local,
  input  logic [2:0] i_credit_in,
  input  logic [2:0] i_full_in,
  output logic [2:0] o_grant,
  output logic [2:0] o_out_x_sw,
  output logic [2:0] o_out_y_sw,
  output logic [2:0] o_out_local_sw,
  output logic       o_credit_err
);

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(CREDIT_DEPTH);

  logic [2:0][1:0] w_dst;
  logic [2:0][2:0] w_req;
  logic [2:0][2:0] w_win;
  logic [2:0][1:0] w_nxt_ptr;
  logic [2:0]      w_grant_nxt;
  logic [2:0]      w_elig;

  logic [2:0][1:0] r_ptr;
  logic [2:0][2:0] r_sw;
  logic [2:0]      r_grant;
  logic            r_arm;

  assign w_dst = {i_req_dst_local, i_req_dst_y, i_req_dst_x};

  // One-hot winner: first requester at or after the pointer, wrapping X->Y->LOCAL.
  function automatic logic [2:0] f_rr(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] win;
    int         idx;
    win = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(ptr) + k) % 3;
      if (req[idx]) win = 3'(1) << idx;
    end
    return win;
  endfunction

  always_comb begin
    w_req       = '0;
    w_win       = '0;
    w_nxt_ptr   = r_ptr;
    w_grant_nxt = '0;
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        w_req[o][i] = i_req_valid[i] && (w_dst[i] == 2'(o));
      end
      if (w_elig[o] && r_arm) w_win[o] = f_rr(w_req[o], r_ptr[o]);
      if (w_win[o][0])      w_nxt_ptr[o] = 2'd1;
      else if (w_win[o][1]) w_nxt_ptr[o] = 2'd2;
      else if (w_win[o][2]) w_nxt_ptr[o] = 2'd0;
      w_grant_nxt = w_grant_nxt | w_win[o];
    end
  end

  // r_arm holds off grants for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm   <= 1'b0;
      r_grant <= '0;
      r_sw    <= {3{`SW_STOP}};
      r_ptr   <= '0;
    end else begin
      r_arm   <= 1'b1;
      r_grant <= w_grant_nxt;
      r_sw    <= w_win;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign o_grant        = r_grant;
  assign o_out_x_sw     = r_sw[0];
  assign o_out_y_sw     = r_sw[1];
  assign o_out_local_sw = r_sw[2];

`ifdef SA_CREDIT_EN
  logic [2:0][CNT_W-1:0] r_cred;
  logic                  r_err;
  logic                  w_unused;

  always_comb begin
    w_elig = '0;
    for (int o = 0; o < 3; o++) w_elig[o] = (r_cred[o] != '0);
  end

  // A simultaneous grant and credit return cancel; an overflowing return is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cred <= {3{c_DEPTH}};
      r_err  <= 1'b0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if ((|w_win[o]) && !i_credit_in[o]) begin
          r_cred[o] <= r_cred[o] - CNT_W'(1);
        end else if (i_credit_in[o] && !(|w_win[o])) begin
          if (r_cred[o] == c_DEPTH) r_err <= 1'b1;
          else                      r_cred[o] <= r_cred[o] + CNT_W'(1);
        end
      end
    end
  end

  assign o_credit_err = r_err;
  assign w_unused     = ^i_full_in;
`else
  logic w_unused;

  assign w_elig       = ~i_full_in;
  assign o_credit_err = 1'b0;
  assign w_unused     = ^{i_credit_in, c_DEPTH};
`endif

endmodule

`default_nettype wire

// File: tb/tb_credit_switch_allocator_3port.sv
// ============================================================================
// Module      : tb_credit_switch_allocator_3port
// Description : Scoreboard bench for credit_switch_allocator_3port with a
//               behavioural reference model (honours SA_CREDIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_credit_switch_allocator_3port;

  localparam int CREDIT_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] i_req_valid = '0;
  logic [1:0] i_req_dst_x = '0, i_req_dst_y = '0, i_req_dst_local = '0;
  logic [2:0] i_credit_in = '0, i_full_in = '0;
  logic [2:0] o_grant, o_out_x_sw, o_out_y_sw, o_out_local_sw;
  logic       o_credit_err;

  credit_switch_allocator_3port #(.CREDIT_DEPTH(CREDIT_DEPTH), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_dst_x(i_req_dst_x), .i_req_dst_y(i_req_dst_y),
    .i_req_dst_local(i_req_dst_local), .i_credit_in(i_credit_in), .i_full_in(i_full_in),
    .o_grant(o_grant), .o_out_x_sw(o_out_x_sw), .o_out_y_sw(o_out_y_sw),
    .o_out_local_sw(o_out_local_sw), .o_credit_err(o_credit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] sw_x;
    logic [2:0] sw_y;
    logic [2:0] sw_l;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   m_ptr[3];
  int   m_cred[3];
  bit   m_err;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < 3; o++) begin
      m_ptr[o]  = 0;
      m_cred[o] = CREDIT_DEPTH;
    end
    m_err = 0;
  endfunction

  // Per output: scan inputs starting at the pointer, first matching requester wins.
  function automatic exp_t model(logic [2:0] v, logic [2:0][1:0] dst,
                                 logic [2:0] cin, logic [2:0] full);
    exp_t       e;
    logic [2:0] sw [3];
    bit         elig;
    int         w, i;
    e = '0;
    for (int o = 0; o < 3; o++) begin
      sw[o] = 3'b000;
      w = -1;
`ifdef SA_CREDIT_EN
      elig = (m_cred[o] > 0);
`else
      elig = !full[o];
`endif
      if (elig) begin
        for (int k = 0; k < 3; k++) begin
          i = (m_ptr[o] + k) % 3;
          if (w < 0 && v[i] && int'(dst[i]) == o) w = i;
        end
      end
      if (w >= 0) begin
        sw[o]      = 3'(1 << w);
        e.grant[w] = 1'b1;
        m_ptr[o]   = (w + 1) % 3;
      end
`ifdef SA_CREDIT_EN
      if (cin[o] && w < 0 && m_cred[o] == CREDIT_DEPTH) m_err = 1;
      else m_cred[o] = m_cred[o] + int'(cin[o]) - ((w >= 0) ? 1 : 0);
`endif
    end
    e.sw_x = sw[0];
    e.sw_y = sw[1];
    e.sw_l = sw[2];
    e.err  = m_err;
    return e;
  endfunction

  exp_t last;

  task automatic step(input logic [2:0] v, input logic [1:0] dx, input logic [1:0] dy,
                      input logic [1:0] dl, input logic [2:0] cin, input logic [2:0] full);
    @(negedge clk);
    i_req_valid = v; i_req_dst_x = dx; i_req_dst_y = dy; i_req_dst_local = dl;
    i_credit_in = cin; i_full_in = full;
    last = model(v, {dl, dy, dx}, cin, full);
    q.push_back(last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req_valid = '0; i_credit_in = '0; i_full_in = '0;
    #1;
    chk("rst_grant", int'(o_grant), 0);
    chk("rst_sw_x", int'(o_out_x_sw), 0);
    chk("rst_sw_y", int'(o_out_y_sw), 0);
    chk("rst_sw_local", int'(o_out_local_sw), 0);
    chk("rst_err", int'(o_credit_err), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last = model(3'b000, '0, 3'b000, 3'b000);
    q.push_back(last);
  endtask

  // Monitor: one expected entry per active clock edge while out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("grant", int'(o_grant), int'(e.grant));
      chk("out_x_sw", int'(o_out_x_sw), int'(e.sw_x));
      chk("out_y_sw", int'(o_out_y_sw), int'(e.sw_y));
      chk("out_local_sw", int'(o_out_local_sw), int'(e.sw_l));
      chk("credit_err", int'(o_credit_err), int'(e.err));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]      pend;
    logic [2:0][1:0] pdst;
    logic [2:0]      cin, full;
    model_reset();
    do_reset();

    repeat (10) step(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    repeat (6)  step(3'b111, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    repeat (2)  step(3'b111, 2'd1, 2'd2, 2'd0, 3'b000, 3'b000);
    repeat (2)  step(3'b111, 2'd3, 2'd3, 2'd3, 3'b000, 3'b000);
    step(3'b001, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    do_reset();

    repeat (12) step(3'b100, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    step(3'b100, 2'd0, 2'd0, 2'd0, 3'b001, 3'b000);
    repeat (4)  step(3'b100, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    do_reset();

    step(3'b001, 2'd1, 2'd0, 2'd0, 3'b010, 3'b000);
    step(3'b000, 2'd0, 2'd0, 2'd0, 3'b010, 3'b000);
    repeat (3) step(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000);
    do_reset();

    pend = '0;
    pdst = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && (last.grant[i] || (pdst[i] == 2'd3 && $urandom_range(7) == 0)))
          pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(9) < 6) begin
          pend[i] = 1'b1;
          pdst[i] = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
        end
      end
      for (int o = 0; o < 3; o++) begin
        full[o] = ($urandom_range(3) == 0);
        cin[o]  = (m_cred[o] < CREDIT_DEPTH) ? ($urandom_range(9) < 3)
                                             : ($urandom_range(49) == 0);
      end
      step(pend, pdst[0], pdst[1], pdst[2], cin, full);
      if ($urandom_range(149) == 0) begin
        do_reset();
        pend = '0;
      end
    end

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
